aes_stream_adapter: RTL and testbench

AES_STREAM_ADAPTER -- requirements
Module: aes_stream_adapter

---
 rtl/aes_stream_adapter.sv | 162 ++++++++++++++++
 tb/tb_aes_stream_adapter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_stream_adapter.sv
// Stream adapter around an AES block core: packs four 32-bit plaintext words into a block,
// runs the core with a completion timeout, then emits the four ciphertext words downstream.
module aes_stream_adapter #(
  parameter int DONE_TIMEOUT = 64
) (
  input  logic         iClk,
  input  logic         iReset_n,
  input  logic         iInValid,
  input  logic [31:0]  iInData,
  output logic         oInReady,
  input  logic [127:0] iKey,
  output logic         oCoreStart,
  output logic [127:0] oCorePlaintext,
  output logic [127:0] oCoreKey,
  input  logic [127:0] iCoreCiphertext,
  input  logic         iCoreDone,
  output logic         oOutValid,
  output logic [31:0]  oOutData,
  output logic         oOutLast,
  input  logic         iOutReady,
  input  logic         iClearErr,
  output logic         oError,
  output logic [15:0]  oBlockCount,
  output logic [1:0]   oDbgState
);

  // Handshakes: a word moves on a cycle where valid and ready are both 1 at the rising edge;
  // valid never waits on ready, and the emitted word/last hold steady while ready is 0.

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_RUN     = 2'd1,
    ST_EMIT    = 2'd2
  } state_e;

  localparam logic [15:0] TIMEOUT_LAST = 16'(DONE_TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [1:0]    wcnt_q, wcnt_d;
  logic [95:0]   words_q, words_d;
  logic [127:0]  pt_q, pt_d;
  logic [127:0]  key_q, key_d;
  logic [127:0]  ct_q, ct_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   timer_q, timer_d;
  logic          err_q, err_d;
  logic [15:0]   blk_q, blk_d;
  logic          timeout;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    words_d = words_q;
    pt_d    = pt_q;
    key_d   = key_q;
    ct_d    = ct_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    blk_d   = blk_q;
    timeout = 1'b0;

    case (state_q)
      ST_COLLECT: begin
        if (iInValid) begin
          // Words 0..2 are staged separately so the block handed to the core stays put
          // while the next block is being collected.
          case (wcnt_q)
            2'd0:    words_d[31:0]  = iInData;
            2'd1:    words_d[63:32] = iInData;
            2'd2:    words_d[95:64] = iInData;
            default: begin
              pt_d    = {iInData, words_q};
              key_d   = iKey;
              timer_d = '0;
              state_d = ST_RUN;
            end
          endcase
          wcnt_d = wcnt_q + 2'd1;
        end
      end
      ST_RUN: begin
        // Completion takes priority over a timer expiring on the same cycle.
        if (iCoreDone) begin
          ct_d    = iCoreCiphertext;
          idx_d   = '0;
          timer_d = '0;
          state_d = ST_EMIT;
        end else if (timer_q == TIMEOUT_LAST) begin
          timeout = 1'b1;
          timer_d = '0;
          state_d = ST_COLLECT;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      ST_EMIT: begin
        if (iOutReady) begin
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            blk_d   = blk_q + 16'd1;
            state_d = ST_COLLECT;
          end
        end
      end
      default: state_d = ST_COLLECT;
    endcase

    if (timeout) begin
      err_d = 1'b1;
    end else if (iClearErr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      state_q <= ST_COLLECT;
      wcnt_q  <= '0;
      words_q <= '0;
      pt_q    <= '0;
      key_q   <= '0;
      ct_q    <= '0;
      idx_q   <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      words_q <= words_d;
      pt_q    <= pt_d;
      key_q   <= key_d;
      ct_q    <= ct_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      blk_q   <= blk_d;
    end
  end

  always_comb begin
    case (idx_q)
      2'd0:    oOutData = ct_q[31:0];
      2'd1:    oOutData = ct_q[63:32];
      2'd2:    oOutData = ct_q[95:64];
      default: oOutData = ct_q[127:96];
    endcase
  end

  assign oInReady       = (state_q == ST_COLLECT);
  assign oCoreStart     = (state_q == ST_RUN);
  assign oOutValid      = (state_q == ST_EMIT);
  assign oOutLast       = (state_q == ST_EMIT) && (idx_q == 2'd3);
  assign oCorePlaintext = pt_q;
  assign oCoreKey       = key_q;
  assign oError         = err_q;
  assign oBlockCount    = blk_q;
  assign oDbgState      = state_q;

endmodule

// File: tb/tb_aes_stream_adapter.sv
// Directed + randomized bench for aes_stream_adapter; the bench itself plays the AES core.
module tb_aes_stream_adapter;

  logic         clk = 1'b0;
  logic         iReset_n;
  logic         iInValid;
  logic [31:0]  iInData;
  logic         oInReady;
  logic [127:0] iKey;
  logic         oCoreStart;
  logic [127:0] oCorePlaintext;
  logic [127:0] oCoreKey;
  logic [127:0] iCoreCiphertext;
  logic         iCoreDone;
  logic         oOutValid;
  logic [31:0]  oOutData;
  logic         oOutLast;
  logic         iOutReady;
  logic         iClearErr;
  logic         oError;
  logic [15:0]  oBlockCount;
  logic [1:0]   oDbgState;

  aes_stream_adapter #(.DONE_TIMEOUT(64)) dut (
    .iClk(clk), .iReset_n(iReset_n), .iInValid(iInValid), .iInData(iInData),
    .oInReady(oInReady), .iKey(iKey), .oCoreStart(oCoreStart),
    .oCorePlaintext(oCorePlaintext), .oCoreKey(oCoreKey),
    .iCoreCiphertext(iCoreCiphertext), .iCoreDone(iCoreDone),
    .oOutValid(oOutValid), .oOutData(oOutData), .oOutLast(oOutLast),
    .iOutReady(iOutReady), .iClearErr(iClearErr), .oError(oError),
    .oBlockCount(oBlockCount), .oDbgState(oDbgState)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [31:0]  exp_q[$];
  logic [15:0]  blk_exp;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // driver: present four plaintext words, W0 first; key is only valid alongside word 3
  task automatic load_block(input logic [127:0] pt, input logic [127:0] key, input bit gaps);
    int n;
    for (int i = 0; i < 4; i++) begin
      if (gaps) begin
        iInValid = 1'b0;
        tick();
      end
      iInValid        = 1'b1;
      iInData         = pt[32*i +: 32];
      iKey            = (i == 3) ? key : ~key;
      iCoreDone       = 1'($urandom_range(0, 1));
      iCoreCiphertext = rand128();
      n = 0;
      while (oInReady !== 1'b1 && n < 200) begin
        tick();
        n++;
      end
      check("in_ready_wait", oInReady, 1);
      if (i == 3) check("start_before_last_accept", oCoreStart, 0);
      tick();
    end
    iInValid  = 1'b0;
    iCoreDone = 1'b0;
    check("start_after_last_accept", oCoreStart, 1);
    check("in_ready_in_run", oInReady, 0);
    check("no_out_in_run", oOutValid, 0);
    check("core_plaintext", oCorePlaintext, pt);
    check("core_key", oCoreKey, key);
    iKey = rand128();
  endtask

  // core model: done arrives on RUN cycle number `delay`
  task automatic core_done(input logic [127:0] ct, input int delay);
    for (int d = 1; d < delay; d++) tick();
    check("start_held_in_run", oCoreStart, 1);
    check("no_out_before_done", oOutValid, 0);
    iCoreDone       = 1'b1;
    iCoreCiphertext = ct;
    tick();
    iCoreDone       = 1'b0;
    iCoreCiphertext = ~ct;
    for (int k = 0; k < 4; k++) exp_q.push_back(ct[32*k +: 32]);
    check("out_valid_after_done", oOutValid, 1);
    check("start_low_in_emit", oCoreStart, 0);
  endtask

  // sink: stall randomly (or hold0 cycles on the first word), consume words from exp_q
  task automatic drain(input int hold0, input int max_stall);
    int stall;
    logic [31:0] w;
    for (int k = 0; k < 4; k++) begin
      stall = (k == 0 && hold0 >= 0) ? hold0 : int'($urandom_range(0, max_stall));
      w = (exp_q.size() != 0) ? exp_q[0] : 32'h0;
      iOutReady = 1'b0;
      for (int s = 0; s < stall; s++) begin
        iInValid = 1'($urandom_range(0, 1));
        iInData  = $urandom;
        tick();
        check("hold_data", oOutData, w);
        check("hold_valid", oOutValid, 1);
        check("hold_in_ready", oInReady, 0);
      end
      iInValid = 1'b0;
      check("out_valid", oOutValid, 1);
      check("out_data", oOutData, w);
      check("out_last", oOutLast, (k == 3));
      iOutReady = 1'b1;
      tick();
      iOutReady = 1'b0;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    blk_exp = blk_exp + 16'd1;
    check("block_count", oBlockCount, blk_exp);
    check("idle_after_emit", oOutValid, 0);
    check("ready_after_emit", oInReady, 1);
  endtask

  initial begin
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] ct;

    iReset_n = 1'b0; iInValid = 1'b0; iInData = '0; iKey = '0;
    iCoreCiphertext = '0; iCoreDone = 1'b0; iOutReady = 1'b0; iClearErr = 1'b0;
    tick();
    tick();
    iReset_n = 1'b1;
    tick();
    check("rst_in_ready", oInReady, 1);
    check("rst_start", oCoreStart, 0);
    check("rst_out_valid", oOutValid, 0);
    check("rst_out_last", oOutLast, 0);
    check("rst_out_data", oOutData, 0);
    check("rst_error", oError, 0);
    check("rst_block_count", oBlockCount, 0);
    check("rst_plaintext", oCorePlaintext, 0);
    check("rst_key", oCoreKey, 0);
    check("rst_dbg_state", oDbgState, 0);
    blk_exp = 16'h0;

    // FIPS-197 block, valid toggling, 5-cycle downstream stall on word 0
    load_block(FIPS_PT, FIPS_KEY, 1'b1);
    core_done(FIPS_CT, 10);
    check("fips_first_word", oOutData, 32'h70b4c55a);
    drain(5, 0);
    check("fips_block_count", oBlockCount, 1);
    check("plaintext_stable", oCorePlaintext, FIPS_PT);

    for (int n = 0; n < 20; n++) begin
      pt = rand128();
      key = rand128();
      ct = rand128();
      load_block(pt, key, 1'($urandom_range(0, 1)));
      core_done(ct, int'($urandom_range(1, 40)));
      drain(-1, 3);
    end

    // core never finishes: timeout after 64 RUN cycles
    load_block(rand128(), rand128(), 1'b0);
    repeat (63) tick();
    check("to_still_run", oCoreStart, 1);
    check("to_no_err_yet", oError, 0);
    tick();
    check("to_error", oError, 1);
    check("to_back_collect", oInReady, 1);
    check("to_start_low", oCoreStart, 0);
    check("to_no_out", oOutValid, 0);
    iCoreDone = 1'b1;
    tick();
    iCoreDone = 1'b0;
    check("stray_done_ignored", oOutValid, 0);
    check("stray_done_no_run", oCoreStart, 0);
    iClearErr = 1'b1;
    tick();
    iClearErr = 1'b0;
    check("clear_err", oError, 0);

    // timeout and clear in the same cycle: timeout wins
    load_block(rand128(), rand128(), 1'b0);
    repeat (63) tick();
    iClearErr = 1'b1;
    tick();
    iClearErr = 1'b0;
    check("to_beats_clear", oError, 1);
    iClearErr = 1'b1;
    tick();
    iClearErr = 1'b0;
    check("clear_err_again", oError, 0);

    // done on the expiry cycle counts as completion
    pt = rand128();
    ct = rand128();
    load_block(pt, rand128(), 1'b0);
    core_done(ct, 64);
    check("done_at_expiry_no_err", oError, 0);
    drain(-1, 2);

    // block counter wrap
    force dut.blk_q = 16'hFFFF;
    tick();
    release dut.blk_q;
    check("preload_count", oBlockCount, 16'hFFFF);
    blk_exp = 16'hFFFF;
    load_block(rand128(), rand128(), 1'b0);
    core_done(rand128(), 3);
    drain(-1, 1);
    check("count_wrapped", oBlockCount, 16'h0000);

    // reset mid-RUN abandons the block
    load_block(rand128(), rand128(), 1'b0);
    tick();
    iReset_n = 1'b0;
    tick();
    iReset_n = 1'b1;
    blk_exp = 16'h0;
    check("rst_run_start", oCoreStart, 0);
    check("rst_run_ready", oInReady, 1);
    check("rst_run_plaintext", oCorePlaintext, 0);
    iCoreDone = 1'b1;
    tick();
    iCoreDone = 1'b0;
    check("rst_run_no_out", oOutValid, 0);

    // reset during EMIT word 2
    ct = rand128();
    load_block(rand128(), rand128(), 1'b0);
    core_done(ct, 4);
    iOutReady = 1'b1;
    tick();
    tick();
    iOutReady = 1'b0;
    check("emit_word2", oOutData, ct[95:64]);
    iReset_n = 1'b0;
    tick();
    iReset_n = 1'b1;
    exp_q.delete();
    check("rst_emit_valid", oOutValid, 0);
    check("rst_emit_count", oBlockCount, 0);
    check("rst_emit_data", oOutData, 0);
    tick();
    check("rst_emit_still_idle", oOutValid, 0);
    load_block(rand128(), rand128(), 1'b1);
    core_done(rand128(), 7);
    drain(-1, 2);
    check("post_reset_count", oBlockCount, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
